rename_freelist_mp: RTL
=======================

Name: rename_freelist_mp

Overview:
- Parametrised multi-port physical-register free list for the rename stage; successor to the single-port free list.
- Serves up to RENAME_WIDTH allocations per cycle to rename lanes and accepts up to COMMIT_WIDTH releases (old_prd) per cycle from commit.
- Keeps a speculative head and an architectural head, so a pipeline flush returns all uncommitted allocations in one cycle.

Parameters:
- NUM_PREG, 64, total physical registers. NUM_PREG-32 must be a power of two.
- RENAME_WIDTH, 2, allocation lanes per cycle.
- COMMIT_WIDTH, 2, release/commit lanes per cycle.
- PREG_W, $clog2(NUM_PREG), physical register index width.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- alloc_req  in  RENAME_WIDTH  per-lane request; lane i is set when lane i renames an rd with need_to_wb and rd!=0.
- alloc_ready  out  1  at least RENAME_WIDTH free entries; independent of alloc_req.
- alloc_preg  out  RENAME_WIDTH*PREG_W  lane i allocated preg at bits [i*PREG_W +: PREG_W]; valid only when alloc_req[i] && alloc_ready.
- rel_valid  in  COMMIT_WIDTH  per-lane release valid.
- rel_preg  in  COMMIT_WIDTH*PREG_W  released old_prd per lane.
- commit_alloc_cnt  in  $clog2(COMMIT_WIDTH+1)  number of committing instructions that allocated a preg this cycle.
- flush  in  1  redirect: restore speculative head.
- free_count  out  $clog2(NUM_PREG-32)+1  current free entries.
- err_double_free  out  1  sticky error (see Optional Feature).

Behaviour:
- Storage: circular array, DEPTH = NUM_PREG-32. Pointers head, arch_head and tail are log2(DEPTH)+1 bits; the MSB is the wrap bit. Index = low bits; arithmetic is modulo 2^(log2(DEPTH)+1).
- Reset (reset_n=0 at posedge):
  - entry[i] = 32+i; head = 0; arch_head = 0; tail = DEPTH (list full); err_double_free = 0.
  - While reset_n=0, alloc_ready = 0 combinationally.
- free_count = tail - head.
- alloc_ready = (free_count >= RENAME_WIDTH) && !flush && reset_n.
- Allocation is combinational, same cycle, matching rename's existing req/resp timing:
  - lane i reads entry[head + popcount(alloc_req[i-1:0])]; lanes are compacted.
  - On fire (alloc_ready && |alloc_req): head += popcount(alloc_req) at the clock edge.
  - All-or-nothing: rename must stall the whole group when alloc_ready=0. alloc_preg for non-requesting lanes is don't-care.
- Release: each rel_valid lane with rel_preg != 0 writes entry[tail + prefix count of valid nonzero lanes]. tail += that count. A release of preg 0 is silently dropped.
- Same-cycle alloc and release: allocation sees pre-release state; no bypass of a released preg into the same cycle.
- Commit: arch_head += commit_alloc_cnt every cycle, including flush cycles.
- Flush:
  - head <= arch_head + commit_alloc_cnt (the post-commit value).
  - Releases in the same cycle still apply.
  - Allocation is blocked because alloc_ready=0.
- Invariants:
  - free_count never exceeds DEPTH; an overflowing release is a design error, covered by a simulation assertion.
  - arch_head never passes head; covered by an assertion.
- Reset mid-operation discards all state and reinitialises the list as full.

Optional Feature:
- Macro: FREELIST_DUP_CHECK_EN.
- When defined:
  - Keep a NUM_PREG-bit free bitmap. Reset value: bits 32..NUM_PREG-1 set.
  - Allocation clears the bit; release sets it.
  - Releasing a preg whose bit is already set, or two lanes releasing the same preg in one cycle, sets err_double_free (sticky until reset).
  - On flush the bitmap is rebuilt: bits of entries between arch_head and old head are set again.
- When not defined: no bitmap; err_double_free is tied to 0.

Decomposition:
- Shared rename package holds:
  - PREG_W derivation and the NUM_ARCH_REG=32 constant.
  - a freelist pointer typedef (wrap bit + index).
  - the popcount/prefix-count function, which the rename lanes also use.
- One sub-module: freelist_prefix_compact. It computes per-lane compacted offsets and the total count from a valid vector, and is instantiated twice: allocation and release.

Test Plan (NUM_PREG=64, RENAME_WIDTH=2, COMMIT_WIDTH=2):
- Reset release, then alloc_req=2'b11 -> alloc_ready=1, alloc_preg lanes = 32, 33; next cycle free_count=30.
- alloc_req=2'b10 after reset -> lane1 gets 32 (compaction); head advances by 1; the next 2'b11 yields 33, 34.
- Allocate 15 pairs (free_count=2), then alloc_req=2'b11 -> fires; free_count=0, alloc_ready=0. Then release 40 and 41 -> free_count=2, the next allocations return 40, 41 (wrap-around).
- Allocate 6 pregs with commit_alloc_cnt=2 once, then flush -> free_count returns to 30, and the next allocation returns 34.
- Same cycle: alloc 2'b11, release {50, 0}, flush=0 -> alloc gets head entries (not 50); tail advances by 1; preg 0 is dropped.
- With FREELIST_DUP_CHECK_EN defined, release 45 while still free -> err_double_free=1 next cycle and stays 1 until reset_n=0.

Source files
------------

// File: rtl/rename_freelist_mp_pkg.sv
// rtl/rename_freelist_mp_pkg.sv - shared rename constants, pointer type and prefix-count helper
//
// Purpose: definitions shared by the free list and the rename lanes.
//   NUM_ARCH_REG      architectural register count; pregs below it are never free-listed
//   fl_ptr_t          free-list pointer (wrap bit + index) for the default 64-preg build
//   prefix_count()    number of set bits in v[n-1:0]; popcount when n is the full width
package rename_freelist_mp_pkg;

  localparam int NUM_ARCH_REG = 32;
  localparam int DEF_NUM_PREG = 64;
  localparam int DEF_PREG_W   = $clog2(DEF_NUM_PREG);
  localparam int DEF_IDX_W    = $clog2(DEF_NUM_PREG - NUM_ARCH_REG);

  // Widest lane vector the helper accepts; rename and commit groups stay far below this.
  localparam int MAX_LANES = 16;

  typedef struct packed {
    logic                 wrap;
    logic [DEF_IDX_W-1:0] idx;
  } fl_ptr_t;

  function automatic int prefix_count(input logic [MAX_LANES-1:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n && v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/rename_freelist_mp_prefix_compact.sv
// rtl/rename_freelist_mp_prefix_compact.sv - per-lane compacted offsets and total count of a valid vector
//
// Purpose: lane i gets the number of valid lanes below it, so valid lanes map onto
//          consecutive free-list slots; total is the number of valid lanes.
// Ports:
//   valid   in   WIDTH          per-lane valid
//   offset  out  WIDTH*CNT_W    lane i offset at [i*CNT_W +: CNT_W]
//   total   out  CNT_W          popcount of valid
module freelist_prefix_compact
  import rename_freelist_mp_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]       valid,
  output logic [WIDTH*CNT_W-1:0] offset,
  output logic [CNT_W-1:0]       total
);

  logic [MAX_LANES-1:0] valid_ext;

  assign valid_ext = MAX_LANES'(valid);

  always_comb begin
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i*CNT_W +: CNT_W] = CNT_W'(prefix_count(valid_ext, i));
    end
    total = CNT_W'(prefix_count(valid_ext, WIDTH));
  end

endmodule

// File: rtl/rename_freelist_mp.sv
// rtl/rename_freelist_mp.sv - multi-port physical register free list with speculative and architectural heads
//
// Purpose: serves up to RENAME_WIDTH same-cycle allocations and takes up to COMMIT_WIDTH
//          releases per cycle; flush rewinds the speculative head to the committed head.
// Optional: define FREELIST_DUP_CHECK_EN to keep a free bitmap that flags double frees.
// Ports:
//   clock, reset_n     clock and synchronous active-low reset
//   alloc_req          per-lane allocation request (lanes compacted)
//   alloc_ready        at least RENAME_WIDTH entries free, not flushing, not in reset
//   alloc_preg         lane i preg at [i*PREG_W +: PREG_W]
//   rel_valid/rel_preg per-lane release of old_prd; preg 0 is dropped
//   commit_alloc_cnt   allocating instructions committing this cycle
//   flush              restore speculative head
//   free_count         tail - head
//   err_double_free    sticky double-free flag (0 without FREELIST_DUP_CHECK_EN)
module rename_freelist_mp
  import rename_freelist_mp_pkg::*;
#(
  parameter int NUM_PREG     = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_W       = $clog2(NUM_PREG)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [RENAME_WIDTH-1:0]          alloc_req,
  output logic                             alloc_ready,
  output logic [RENAME_WIDTH*PREG_W-1:0]   alloc_preg,
  input  logic [COMMIT_WIDTH-1:0]          rel_valid,
  input  logic [COMMIT_WIDTH*PREG_W-1:0]   rel_preg,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_alloc_cnt,
  input  logic                             flush,
  output logic [$clog2(NUM_PREG-32):0]     free_count,
  output logic                             err_double_free
);

  localparam int DEPTH  = NUM_PREG - NUM_ARCH_REG;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int ACNT_W = $clog2(RENAME_WIDTH + 1);
  localparam int RCNT_W = $clog2(COMMIT_WIDTH + 1);

  logic [PREG_W-1:0] entry [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  arch_head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  arch_next;

  logic [RENAME_WIDTH*ACNT_W-1:0] alloc_off;
  logic [ACNT_W-1:0]              alloc_total;
  logic [COMMIT_WIDTH-1:0]        rel_ok;
  logic [COMMIT_WIDTH*RCNT_W-1:0] rel_off;
  logic [RCNT_W-1:0]              rel_total;
  logic [PTR_W-1:0]               alloc_ptr [RENAME_WIDTH];
  logic [PTR_W-1:0]               rel_ptr   [COMMIT_WIDTH];
  logic                           fire;

  freelist_prefix_compact #(.WIDTH(RENAME_WIDTH), .CNT_W(ACNT_W)) u_alloc_compact (
    .valid  (alloc_req),
    .offset (alloc_off),
    .total  (alloc_total)
  );

  freelist_prefix_compact #(.WIDTH(COMMIT_WIDTH), .CNT_W(RCNT_W)) u_rel_compact (
    .valid  (rel_ok),
    .offset (rel_off),
    .total  (rel_total)
  );

  assign free_count  = tail - head;
  assign alloc_ready = reset_n && !flush && (free_count >= PTR_W'(RENAME_WIDTH));
  assign fire        = alloc_ready && (|alloc_req);
  assign arch_next   = arch_head + PTR_W'(commit_alloc_cnt);

  // Reads use the pre-release array, so a preg released this cycle is never handed out
  // in the same cycle.
  for (genvar i = 0; i < RENAME_WIDTH; i++) begin : g_alloc
    assign alloc_ptr[i] = head + PTR_W'(alloc_off[i*ACNT_W +: ACNT_W]);
    assign alloc_preg[i*PREG_W +: PREG_W] = entry[alloc_ptr[i][IDX_W-1:0]];
  end

  for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_rel
    assign rel_ok[i]  = rel_valid[i] && (rel_preg[i*PREG_W +: PREG_W] != '0);
    assign rel_ptr[i] = tail + PTR_W'(rel_off[i*RCNT_W +: RCNT_W]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PREG_W'(NUM_ARCH_REG + i);
      end
      head      <= '0;
      arch_head <= '0;
      tail      <= PTR_W'(DEPTH);
    end else begin
      arch_head <= arch_next;
      // Flush lands on the post-commit head so this cycle's commits are kept.
      if (flush) begin
        head <= arch_next;
      end else if (fire) begin
        head <= head + PTR_W'(alloc_total);
      end
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (rel_ok[i]) begin
          entry[rel_ptr[i][IDX_W-1:0]] <= rel_preg[i*PREG_W +: PREG_W];
        end
      end
      tail <= tail + PTR_W'(rel_total);
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [NUM_PREG-1:0] free_map;
  logic [NUM_PREG-1:0] free_map_next;
  logic [PTR_W-1:0]    restore_span;
  logic [IDX_W-1:0]    dist;
  logic                dup_hit;
  logic                err_q;

  assign restore_span = head - arch_next;

  always_comb begin
    free_map_next = free_map;
    dup_hit       = 1'b0;
    dist          = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (fire && alloc_req[i]) free_map_next[alloc_preg[i*PREG_W +: PREG_W]] = 1'b0;
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (rel_ok[i]) begin
        if (free_map[rel_preg[i*PREG_W +: PREG_W]]) dup_hit = 1'b1;
        for (int j = 0; j < i; j++) begin
          if (rel_ok[j] && rel_preg[j*PREG_W +: PREG_W] == rel_preg[i*PREG_W +: PREG_W]) dup_hit = 1'b1;
        end
        free_map_next[rel_preg[i*PREG_W +: PREG_W]] = 1'b1;
      end
    end
    // Entries from the post-commit head up to the old speculative head become free again.
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        dist = IDX_W'(k) - arch_next[IDX_W-1:0];
        if ({1'b0, dist} < restore_span) free_map_next[entry[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      free_map <= {{DEPTH{1'b1}}, {NUM_ARCH_REG{1'b0}}};
      err_q    <= 1'b0;
    end else begin
      free_map <= free_map_next;
      if (dup_hit) err_q <= 1'b1;
    end
  end

  assign err_double_free = err_q;
`else
  assign err_double_free = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n) begin
      a_no_overflow: assert (free_count <= PTR_W'(DEPTH));
      a_arch_behind: assert ((head - arch_head) <= PTR_W'(DEPTH));
    end
  end
`endif

endmodule
